// File: rtl/acq_seq_pkg.sv
// rtl/acq_seq_pkg.sv - shared state encoding and defaults for the acquisition sequencer
//
// Purpose: one place for the sequencer state encoding, the sensor frame
// geometry and the default watchdog limit, so that the top level, its timer
// and any debug tooling agree on them.
package acq_seq_pkg;

  localparam int ACQ_PIXELS_PER_FRAME = 1024;
  localparam int ACQ_TIMEOUT_CYCLES   = 400000;
  localparam int DBG_STATE_W          = 4;
  localparam int SENSOR_INDEX_W       = 10;
  localparam int FRAME_CNT_W          = 16;

  typedef enum logic [DBG_STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_TRIGGER     = 4'd1,
    ST_ACQUIRE     = 4'd2,
    ST_WAIT_PERIOD = 4'd3
  } acq_state_t;

endpackage

// File: rtl/acq_interval_timer.sv
// rtl/acq_interval_timer.sv - saturating interval counter with synchronous clear and enable
//
// Purpose: counts enabled master_clock cycles and holds at all-ones instead
// of wrapping, so a long stall can never alias back to a small value.
// Ports:
//   master_clock  clock
//   reset         synchronous active-high reset, count -> 0
//   clear         synchronous clear, takes priority over enable
//   enable        count up by one this cycle (unless saturated)
//   count         current count
module acq_interval_timer #(
  parameter int W = 32
) (
  input  logic         master_clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge master_clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/acquisition_sequencer.sv
// rtl/acquisition_sequencer.sv - frame trigger / acquisition sequencer with period and watchdog timing
//
// Purpose: issues frame_trigger pulses at a fixed period, waits for the last
// pixel of each frame from the sensor driver, and runs either continuously
// or for a burst of frames. Flags period overruns and watchdog expiry.
// Ports:
//   master_clock, reset            clock and synchronous active-high reset
//   cfg_start, cfg_stop            one-cycle control pulses
//   cfg_burst, cfg_frame_count     run mode and burst length (latched on start)
//   cfg_period                     trigger spacing in cycles (latched on start)
//   sensor_valid, sensor_index     pixel stream position from the sensor driver
//   frame_trigger, frame_id        trigger pulse and current frame number
//   busy, acq_done                 activity level and end-of-run pulse
//   frames_done                    completed frames in this run
//   overrun, timeout_err           sticky error flags
//   dbg_state                      current state encoding
module acquisition_sequencer
  import acq_seq_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = ACQ_PIXELS_PER_FRAME,
  parameter int TIMEOUT_CYCLES   = ACQ_TIMEOUT_CYCLES,
  parameter int PERIOD_W         = 32
) (
  input  logic                      master_clock,
  input  logic                      reset,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic                      cfg_burst,
  input  logic [FRAME_CNT_W-1:0]    cfg_frame_count,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      sensor_valid,
  input  logic [SENSOR_INDEX_W-1:0] sensor_index,
  output logic                      frame_trigger,
  output logic [FRAME_CNT_W-1:0]    frame_id,
  output logic                      busy,
  output logic                      acq_done,
  output logic [FRAME_CNT_W-1:0]    frames_done,
  output logic                      overrun,
  output logic                      timeout_err,
  output logic [DBG_STATE_W-1:0]    dbg_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry is decided one cycle early so acq_done lands exactly
  // TIMEOUT_CYCLES cycles after the trigger.
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SENSOR_INDEX_W-1:0] LAST_PIXEL = SENSOR_INDEX_W'(PIXELS_PER_FRAME - 1);

  acq_state_t state, state_next;

  logic                   burst_q, burst_next;
  logic [FRAME_CNT_W-1:0] count_q, count_next;
  logic [PERIOD_W-1:0]    period_q, period_next;
  logic                   stop_pending, stop_pending_next;
  logic [FRAME_CNT_W-1:0] frame_id_next;
  logic [FRAME_CNT_W-1:0] frames_done_next;
  logic                   overrun_next;
  logic                   timeout_next;
  logic                   acq_done_next;

  logic [PERIOD_W-1:0]    period_count;
  logic [WD_W-1:0]        wd_count;
  logic                   timer_clear;
  logic                   timer_enable;

  logic                   stop_req;
  logic                   frame_complete;
  logic                   short_period;
  logic                   period_reached;
  logic                   wd_expired;
  logic [FRAME_CNT_W-1:0] frames_done_inc;

  // Both timers share control: they restart on the way into TRIGGER (and
  // IDLE), then count every cycle spent in ACQUIRE or WAIT_PERIOD. Because
  // the increment is keyed on the next state, the count equals the number
  // of cycles since the trigger cycle.
  assign timer_clear  = (state_next == ST_TRIGGER) || (state_next == ST_IDLE);
  assign timer_enable = (state_next == ST_ACQUIRE) || (state_next == ST_WAIT_PERIOD);

  acq_interval_timer #(.W(PERIOD_W)) u_period_timer (
    .master_clock (master_clock),
    .reset        (reset),
    .clear        (timer_clear),
    .enable       (timer_enable),
    .count        (period_count)
  );

  acq_interval_timer #(.W(WD_W)) u_watchdog (
    .master_clock (master_clock),
    .reset        (reset),
    .clear        (timer_clear),
    .enable       (timer_enable),
    .count        (wd_count)
  );

  assign stop_req        = cfg_stop || stop_pending;
  assign frame_complete  = sensor_valid && (sensor_index == LAST_PIXEL);
  // Periods of 0 or 1 cannot be met by any frame; treat them as "as fast
  // as possible" rather than as a permanent overrun.
  assign short_period    = (period_q <= PERIOD_W'(1));
  assign period_reached  = short_period || (period_count >= (period_q - PERIOD_W'(1)));
  assign wd_expired      = (wd_count >= WD_LAST);
  assign frames_done_inc = frames_done + FRAME_CNT_W'(1);

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      burst_q      <= 1'b0;
      count_q      <= '0;
      period_q     <= '0;
      stop_pending <= 1'b0;
      frame_id     <= '0;
      frames_done  <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      acq_done     <= 1'b0;
    end else begin
      state        <= state_next;
      burst_q      <= burst_next;
      count_q      <= count_next;
      period_q     <= period_next;
      stop_pending <= stop_pending_next;
      frame_id     <= frame_id_next;
      frames_done  <= frames_done_next;
      overrun      <= overrun_next;
      timeout_err  <= timeout_next;
      acq_done     <= acq_done_next;
    end
  end

  always_comb begin
    state_next        = state;
    burst_next        = burst_q;
    count_next        = count_q;
    period_next       = period_q;
    frame_id_next     = frame_id;
    frames_done_next  = frames_done;
    overrun_next      = overrun;
    timeout_next      = timeout_err;
    acq_done_next     = 1'b0;
    stop_pending_next = stop_pending;

    unique case (state)
      ST_IDLE: begin
        // A simultaneous stop cancels the start entirely.
        if (cfg_start && !cfg_stop) begin
          burst_next       = cfg_burst;
          count_next       = cfg_frame_count;
          period_next      = cfg_period;
          frames_done_next = '0;
          frame_id_next    = '0;
          overrun_next     = 1'b0;
          timeout_next     = 1'b0;
          if (cfg_burst && (cfg_frame_count == '0)) begin
            acq_done_next = 1'b1;
          end else begin
            state_next    = ST_TRIGGER;
            frame_id_next = FRAME_CNT_W'(1);
          end
        end
      end

      ST_TRIGGER: begin
        if (stop_req) begin
          state_next    = ST_IDLE;
          acq_done_next = 1'b1;
        end else begin
          state_next = ST_ACQUIRE;
        end
      end

      ST_ACQUIRE: begin
        // A completing frame wins over a watchdog expiring in the same cycle.
        if (frame_complete) begin
          frames_done_next = frames_done_inc;
          if ((burst_q && (frames_done_inc == count_q)) || stop_req) begin
            state_next    = ST_IDLE;
            acq_done_next = 1'b1;
          end else begin
            state_next = ST_WAIT_PERIOD;
            if (period_reached && !short_period) begin
              overrun_next = 1'b1;
            end
          end
        end else if (wd_expired) begin
          timeout_next  = 1'b1;
          state_next    = ST_IDLE;
          acq_done_next = 1'b1;
        end
      end

      ST_WAIT_PERIOD: begin
        if (stop_req) begin
          state_next    = ST_IDLE;
          acq_done_next = 1'b1;
        end else if (period_reached) begin
          state_next    = ST_TRIGGER;
          frame_id_next = frame_id + FRAME_CNT_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (state_next == ST_IDLE) begin
      stop_pending_next = 1'b0;
    end else if (cfg_stop) begin
      stop_pending_next = 1'b1;
    end
  end

  assign frame_trigger = (state == ST_TRIGGER);
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

endmodule

// File: doc/acquisition_sequencer.md
ACQUISITION_SEQUENCER -- requirements
Module: acquisition_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
 - PIXELS_PER_FRAME, 1024, sensor pixels per frame.
 - TIMEOUT_CYCLES, 400000, watchdog limit in master_clock cycles from trigger to last pixel.
 - PERIOD_W, 32, width of the frame-period configuration.
REQ-002 Ports, one per line: name  direction  width  meaning. One clock; reset is synchronous and active-high.
 - master_clock  in  1  sole clock, 40 MHz.
 - reset  in  1  synchronous, active-high reset.
 - cfg_start  in  1  one-cycle pulse; arms the sequencer.
 - cfg_stop  in  1  one-cycle pulse; requests an orderly stop.
 - cfg_burst  in  1  0 = continuous, 1 = burst of cfg_frame_count frames.
 - cfg_frame_count  in  16  number of frames in burst mode.
 - cfg_period  in  PERIOD_W  cycles from one frame_trigger to the next.
 - sensor_valid  in  1  pixel valid from the sensor driver.
 - sensor_index  in  10  pixel index from the sensor driver.
 - frame_trigger  out  1  one-cycle pulse that starts sensor integration.
 - frame_id  out  16  frame number, updated with each frame_trigger.
 - busy  out  1  high in every state except IDLE.
 - acq_done  out  1  one-cycle pulse on return to IDLE.
 - frames_done  out  16  frames completed since the last accepted cfg_start.
 - overrun  out  1  sticky: the period expired before the frame completed.
 - timeout_err  out  1  sticky: the watchdog expired.
 - dbg_state  out  4  current state encoding.

Function
REQ-003 States: IDLE=0, TRIGGER=1, ACQUIRE=2, WAIT_PERIOD=3.
REQ-004 IDLE: on cfg_start, latch cfg_burst, cfg_frame_count and cfg_period; clear frames_done, frame_id, overrun and timeout_err; go to TRIGGER.
REQ-005 IDLE, cfg_start and cfg_stop in the same cycle: stop wins; remain in IDLE with no acq_done.
REQ-006 IDLE, burst mode with cfg_frame_count=0: emit acq_done the next cycle; no trigger.
REQ-007 TRIGGER: frame_trigger=1 for exactly one cycle; frame_id increments (first frame_id=1); period counter and watchdog clear to 0; go to ACQUIRE.
REQ-008 Period counter and watchdog increment every cycle outside IDLE and TRIGGER; both saturate.
REQ-009 ACQUIRE frame complete = sensor_valid=1 and sensor_index=PIXELS_PER_FRAME-1; in that cycle frames_done increments.
REQ-010 On frame complete: if burst and frames_done+1 equals the latched count, or a stop is pending, go to IDLE with acq_done; otherwise go to WAIT_PERIOD.
REQ-011 WAIT_PERIOD: go to TRIGGER when the period counter is at or above the latched period-1. Trigger spacing is therefore exactly cfg_period cycles when the frame completes in time.
REQ-012 If the period counter has already reached period-1 at frame completion: set overrun; the next TRIGGER follows after one WAIT_PERIOD cycle. cfg_period=0 or 1 gives back-to-back frames and does not set overrun.
REQ-013 Watchdog reaches TIMEOUT_CYCLES in ACQUIRE: set timeout_err; go to IDLE with acq_done; frames_done is unchanged.
REQ-014 cfg_stop while busy sets stop_pending.
 - ACQUIRE: the current frame finishes, then go to IDLE.
 - TRIGGER or WAIT_PERIOD: go to IDLE next cycle with acq_done, no further trigger.
REQ-015 cfg_start while busy is ignored; configuration inputs are sampled only at the accepted cfg_start.
REQ-016 sensor_valid outside ACQUIRE is ignored.
REQ-017 frames_done and frame_id wrap modulo 2^16.

Reset
REQ-018 reset=1 on a master_clock edge forces IDLE; all outputs, counters and stop_pending go to 0 on that edge, including mid-frame; no acq_done is emitted.
REQ-019 Only reset clears overrun and timeout_err outside an accepted cfg_start.

Structure
REQ-020 Shared package acq_seq_pkg holds the state encoding, PIXELS_PER_FRAME, the TIMEOUT_CYCLES default and the dbg_state width.
REQ-021 One sub-module, acq_interval_timer, implements a saturating clear/enable counter; it is instantiated twice, once for the period counter and once for the watchdog.

Verification
REQ-022 Continuous, period=2000, frame completes at cycle 1100 -> triggers exactly 2000 cycles apart, overrun=0, frame_id 1,2,3...
REQ-023 Burst, count=3 -> exactly 3 triggers, acq_done one cycle after the third last pixel, frames_done=3, busy then 0.
REQ-024 Period=500, frame takes 1100 cycles -> overrun=1, next trigger 2 cycles after the last pixel.
REQ-025 No sensor_valid, TIMEOUT_CYCLES=1000 -> timeout_err=1 and acq_done 1000 cycles after the trigger, frames_done=0.
REQ-026 cfg_stop in mid ACQUIRE, then again in WAIT_PERIOD -> current frame completes then IDLE; in WAIT_PERIOD, IDLE next cycle with no trigger; cfg_start and cfg_stop together in IDLE -> no trigger.
REQ-027 reset at pixel 500 -> all outputs 0 the next cycle; a following cfg_start yields frame_id=1.
